alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Iterative multiply/divide unit implementing RV32M ops, a parametrised companion to the single-cycle ALU.
//  Sits beside the ALU in the execute stage.
//  Accepts one operation via valid/ready and computes it one bit per cycle (shift-add / restoring divide).
//  Returns the result via valid/ready with a zero flag matching ALU semantics.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; even, >= 4
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      unit can accept; high only in IDLE
//  op         in   3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  src_a      in   WIDTH  multiplicand / dividend
//  src_b      in   WIDTH  multiplier / divisor
//  flush      in   1      synchronous abort of the in-flight op
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  result of the op
//  zero       out  1      (result == 0); valid only while out_valid
//  busy       out  1      high in CALC or DONE
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; zero=1.
//   - Counter and internal registers are cleared.
//  Accept:
//   - On the edge where in_valid && in_ready, op/src_a/src_b are latched.
//   - Inputs are ignored at all other times.
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   - IDLE->CALC on accept; counter loaded with WIDTH.
//   - CALC: one iteration per cycle, counter-1.
//     - On the last iteration, sign fix-up and result select occur; next state is DONE.
//   - DONE: out_valid=1; result/zero held stable until out_ready. Then IDLE.
//   - Latency: out_valid rises exactly WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
//   - Back-to-back: new accept is possible the cycle after handshake, since in_ready=1 in IDLE.
//  Fast path (accept -> DONE directly, out_valid 1 cycle after accept):
//   - Divide by zero: DIV/DIVU give all-ones; REM/REMU give src_a.
//   - Signed overflow DIV(-2^(W-1), -1): quotient = src_a; REM gives 0.
//  Arithmetic:
//   - Full 2*WIDTH product.
//   - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
//     - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
//   - Signed divide runs on magnitudes.
//     - Quotient is negated if the operand signs differ.
//     - Remainder takes the sign of the dividend; quotient truncates toward zero.
//  Flush:
//   - In CALC or DONE, flush returns the FSM to IDLE on the next edge; out_valid=0, result discarded.
//   - Flush in IDLE has no effect.
//   - Flush has priority over out_ready and accept in the same cycle.
//  Reset mid-operation:
//   - Async rst immediately forces the reset values; the in-flight op is lost.
// TESTING
//  MUL  a=7,b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept
//  MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1,b=2 -> 0xFFFFFFFF
//  DIVU 100/7 -> 14, REMU -> 2; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIV 0/5 -> 0, zero=1
//  DIV x/0 -> 0xFFFFFFFF and REM x/0 -> x in 1 cycle; DIV 0x80000000/-1 -> 0x80000000, REM -> 0
//  out_ready low 5 cycles in DONE -> result/out_valid stable, in_ready=0; new op accepted the cycle after handshake
//  rst pulse at CALC cycle 10, then flush at CALC cycle 5 of a new op -> IDLE, no out_valid; next op completes correctly

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready on both sides and a synchronous flush.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam int         CW        = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             neg_q, neg_r;

  logic             accept, a_signed, b_signed, sa, sb;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] mag_a, mag_b, fast_res;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, final_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  // Operand decode: signed ops run on magnitudes and fix the sign at the end.
  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa       = a_signed && src_a[WIDTH-1];
  assign sb       = b_signed && src_b[WIDTH-1];
  assign mag_a    = sa ? -src_a : src_a;
  assign mag_b    = sb ? -src_b : src_b;

  // Divide by zero and signed overflow bypass the iteration entirely.
  assign div_zero = op[2] && (src_b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (src_a == MIN_NEG) && (src_b == '1);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (op[1] ? src_a : '1) : (op[1] ? '0 : src_a);

  // One multiply step adds the multiplicand then shifts {acc_hi, acc_lo} right;
  // one divide step shifts the next dividend bit into the partial remainder.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    prod      = {acc_hi, acc_lo};
    quo       = acc_lo;
    rem       = acc_hi;
    final_res = '0;
    if (neg_q) begin
      prod = -prod;
      quo  = -acc_lo;
    end
    if (neg_r) rem = -acc_hi;
    case (op_q)
      OP_MUL:                       final_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are plain flops, so they are all reset with the FSM.
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else if (accept) begin
      op_q   <= op;
      cnt    <= CW'(WIDTH);
      acc_hi <= '0;
      acc_lo <= op[2] ? mag_a : mag_b;
      opb    <= op[2] ? mag_b : mag_a;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      if (fast) begin
        result <= fast_res;
        zero   <= (fast_res == '0);
      end
    end else if (state == CALC && !flush) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (op_q[2]) begin
          acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end else begin
        result <= final_res;
        zero   <= (final_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: a 64-bit arithmetic reference model and a
// per-cycle monitor that tracks pending results, latency, flush and reset.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, flush, out_valid, out_ready, zero, busy;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b, result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stall_left = 0;
  bit rand_ready = 1'b0;

  logic [W-1:0] pend_res[$];
  int           pend_due[$];

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [W-1:0]    r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      3'd0: begin pu = ua * ub; r = pu[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin pu = ua * ub; r = pu[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Consumer side: directed stalls first, otherwise always ready or random.
  always @(negedge clk) begin
    if (stall_left > 0) begin
      out_ready = 1'b0;
      if (out_valid) stall_left--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(posedge rst) begin
    pend_res.delete();
    pend_due.delete();
  end

  // Monitor: checks every cycle, then applies what the coming edge will do.
  logic has, ov;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      has = (pend_res.size() > 0);
      ov  = has && (cyc >= pend_due[0]);
      check("in_ready", in_ready, !has);
      check("busy", busy, has);
      check("out_valid", out_valid, ov);
      if (ov) begin
        check("result", result, pend_res[0]);
        check("zero", zero, pend_res[0] == 0);
      end
      if (has && (flush || (ov && out_ready))) begin
        void'(pend_res.pop_front());
        void'(pend_due.pop_front());
      end else if (!has && in_valid) begin
        pend_res.push_back(model(op, src_a, src_b));
        pend_due.push_back(cyc + 1 + (is_fast(op, src_a, src_b) ? 0 : W + 1));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge right after the accept edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    for (int t = 0; t < 400 && !got; t++) begin
      #1 got = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    rst = 1'b0;
    idle(1);

    // Hand-computed values that pin the reference model.
    check("pin_mul", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulh", model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_mulhu", model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu", model(3'd5, 32'd100, 32'd7), 32'd14);
    check("pin_remu", model(3'd7, 32'd100, 32'd7), 32'd2);
    check("pin_div_neg", model(3'd4, -32'd7, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem_neg", model(3'd6, -32'd7, 32'd2), 32'hFFFF_FFFF);
    check("pin_div0", model(3'd4, 32'd1234, 32'd0), 32'hFFFF_FFFF);
    check("pin_rem0", model(3'd6, 32'd1234, 32'd0), 32'd1234);
    check("pin_ovf_div", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_ovf_rem", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    // Latency of a full-length op, counted from the accept edge.
    send(3'd0, 32'd7, 32'hFFFF_FFFD);
    lat = 0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    check("mul_latency", lat, W + 1);
    idle(2);

    // Fast path: out_valid in the cycle right after accept.
    send(3'd4, 32'd55, 32'd0);
    #1 check("div0_fast_valid", out_valid, 1);
    idle(2);

    // Directed list, issued back to back.
    send(3'd1, 32'h8000_0000, 32'h8000_0000);
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(3'd2, 32'hFFFF_FFFF, 32'd2);
    send(3'd5, 32'd100, 32'd7);
    send(3'd7, 32'd100, 32'd7);
    send(3'd4, -32'd7, 32'd2);
    send(3'd6, -32'd7, 32'd2);
    send(3'd4, 32'd0, 32'd5);
    send(3'd6, 32'd99, 32'd0);
    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(3);

    // Consumer stalls for 5 cycles in DONE, followed by an immediate new op.
    stall_left = 5;
    send(3'd5, 32'd100, 32'd7);
    send(3'd0, 32'd3, 32'd5);
    idle(40);

    // Async reset mid-calculation.
    send(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(10);
    #3 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Flush at CALC cycle 5, then a normal op.
    send(3'd4, -32'd100, 32'd3);
    idle(4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(3);
    send(3'd6, -32'd100, 32'd3);
    idle(40);

    // Randomised phase with random consumer backpressure and occasional flushes.
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(0, 40));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    end

    for (int t = 0; t < 2000 && pend_res.size() > 0; t++) @(negedge clk);
    check("drain_pending", pend_res.size(), 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
